// File: rtl/matrix_c_reader_pkg.sv
// matrix_c_reader_pkg
// Shared definitions for the matrix C drain path: FSM state encodings,
// the result word width and the beat record carried through the skid FIFO.
package matrix_c_reader_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // One buffered result: the word plus its end-of-matrix marker.
    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] data;
    } c_beat_t;

endpackage

// File: rtl/matrix_c_reader_fifo.sv
// result_skid_fifo
// Two-entry first-word-fall-through FIFO between the BRAM return and the
// output stream. When empty, an incoming word is presented on head in the
// same cycle, so a ready consumer sees no added latency.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   push         write push_data this cycle
//   push_data    entry being written
//   pop          consumer takes head this cycle (only while valid)
//   valid        head holds a real entry (buffered or passing through)
//   head         oldest entry, or push_data when the FIFO is empty
//   count        buffered entries, 0..2
module result_skid_fifo
    import matrix_c_reader_pkg::*;
#(
    parameter int W = WORD_W + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         bypass;

    // Empty FIFO with push and pop together: the word goes straight through.
    assign bypass = (count == 2'd0) && push && pop;
    // Next free slot; with two entries and push+pop on full it is the slot
    // being vacated, which is rd_ptr itself.
    assign wr_ptr = rd_ptr ^ count[0];

    assign valid = (count != 2'd0) || push;
    assign head  = (count != 2'd0) ? mem[rd_ptr] : push_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push && !bypass)
                mem[wr_ptr] <= push_data;
            if (pop && (count != 2'd0))
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/matrix_c_reader.sv
// matrix_c_reader
// Drains an M x N result matrix from the C BRAM in row-major order and
// streams it out as valid/ready beats, with the final beat flagged.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a drain (only looked at while idle)
//   M_val, N_val    rows / columns to drain, latched on accepted start
//   busy            drain in progress
//   done            one-cycle pulse after the last beat is accepted
//   matrix_C_en     BRAM read strobe
//   matrix_C_addr   BRAM read address (r*N_val + c)
//   matrix_C_rdata  BRAM data, one cycle after matrix_C_en
//   out_valid/out_ready/out_data/out_last  result stream
module matrix_c_reader
    import matrix_c_reader_pkg::*;
#(
    parameter int MAX_M       = 16,
    parameter int MAX_N       = 16,
    parameter int ADDR_M_BITS = $clog2(MAX_M),
    parameter int ADDR_N_BITS = $clog2(MAX_N),
    parameter int ADDR_C_BITS = $clog2(MAX_M * MAX_N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_M_BITS:0]   M_val,
    input  logic [ADDR_N_BITS:0]   N_val,
    output logic                   busy,
    output logic                   done,
    output logic                   matrix_C_en,
    output logic [ADDR_C_BITS-1:0] matrix_C_addr,
    input  logic [WORD_W-1:0]      matrix_C_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_W-1:0]      out_data,
    output logic                   out_last
);

    localparam logic [ADDR_M_BITS:0]   ONE_M = (ADDR_M_BITS+1)'(1);
    localparam logic [ADDR_N_BITS:0]   ONE_N = (ADDR_N_BITS+1)'(1);
    localparam logic [ADDR_C_BITS-1:0] ONE_C = ADDR_C_BITS'(1);

    logic [1:0]             state;
    logic [ADDR_M_BITS:0]   m_q;
    logic [ADDR_N_BITS:0]   n_q;
    logic [ADDR_M_BITS:0]   row;
    logic [ADDR_N_BITS:0]   col;
    logic [ADDR_C_BITS-1:0] addr_q;
    logic                   rd_inflight;
    logic                   rd_inflight_last;
    logic                   done_q;

    logic                   issue;
    logic                   last_rd;
    logic                   pop;
    logic [2:0]             pending;
    logic [1:0]             occ;
    logic                   fifo_valid;
    c_beat_t                push_beat;
    c_beat_t                head_beat;

    assign last_rd = (row == m_q - ONE_M) && (col == n_q - ONE_N);
    assign pop     = fifo_valid && out_ready;

    // Buffered words plus the one in flight, less what leaves this cycle,
    // must stay below 2 so the next return always has a slot.
    assign pending = 3'(occ) + 3'(rd_inflight);
    assign issue   = (state == ST_RUN) && (pending < 3'd2 + 3'(pop));

    assign push_beat.last = rd_inflight_last;
    assign push_beat.data = matrix_C_rdata;

    result_skid_fifo #(.W(WORD_W + 1)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_inflight),
        .push_data (push_beat),
        .pop       (pop),
        .valid     (fifo_valid),
        .head      (head_beat),
        .count     (occ)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            m_q              <= '0;
            n_q              <= '0;
            row              <= '0;
            col              <= '0;
            addr_q           <= '0;
            rd_inflight      <= 1'b0;
            rd_inflight_last <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            done_q           <= 1'b0;
            rd_inflight      <= issue;
            rd_inflight_last <= issue && last_rd;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if ((M_val != '0) && (N_val != '0)) begin
                            state  <= ST_RUN;
                            m_q    <= M_val;
                            n_q    <= N_val;
                            row    <= '0;
                            col    <= '0;
                            addr_q <= '0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        // Row/column walk; the flat address just counts up.
                        addr_q <= addr_q + ONE_C;
                        if (col == n_q - ONE_N) begin
                            col <= '0;
                            row <= row + ONE_M;
                        end else begin
                            col <= col + ONE_N;
                        end
                        if (last_rd)
                            state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && head_beat.last) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy          = (state != ST_IDLE);
    assign done          = done_q;
    assign matrix_C_en   = issue;
    assign matrix_C_addr = addr_q;
    assign out_valid     = fifo_valid;
    assign out_data      = fifo_valid ? head_beat.data : '0;
    assign out_last      = fifo_valid && head_beat.last;

endmodule

// File: tb/tb_matrix_c_reader.sv
// tb_matrix_c_reader
// Randomized drains of matrix C checked against a behavioural model of the
// stream: expected beats come from the BRAM image in address order, done
// follows the last handshake by one cycle, reads never run more than two
// ahead of accepted beats.
module tb_matrix_c_reader;

    localparam int AM = 4;
    localparam int AN = 4;
    localparam int AC = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AM:0]   M_val;
    logic [AN:0]   N_val;
    logic          busy;
    logic          done;
    logic          en;
    logic [AC-1:0] addr;
    logic [31:0]   rdata;
    logic          valid;
    logic          out_ready;
    logic [31:0]   data;
    logic          last;

    always #5 clk = ~clk;

    matrix_c_reader #(.MAX_M(16), .MAX_N(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .M_val          (M_val),
        .N_val          (N_val),
        .busy           (busy),
        .done           (done),
        .matrix_C_en    (en),
        .matrix_C_addr  (addr),
        .matrix_C_rdata (rdata),
        .out_valid      (valid),
        .out_ready      (out_ready),
        .out_data       (data),
        .out_last       (last)
    );

    // BRAM image; read data appears one cycle after the enable.
    logic [31:0] mem [256];
    always @(posedge clk) if (en) rdata <= mem[addr];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int scen = 0;
    int rdy_mode = 0;
    int to_cnt = 0;
    bit finish_req = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Compare process: model of what the stream must look like each cycle.
    initial begin : compare
        bit          rst_prev = 1'b0;
        bit          m_busy = 1'b0;
        bit          acc_pend = 1'b0;
        bit          done_due = 1'b0;
        bit          done_next;
        bit          prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        logic        prev_last = 1'b0;
        int          m_total = 0;
        int          m_rd = 0;
        int          m_beat = 0;
        int          m_start = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (finish_req) begin
                chk("timeouts", to_cnt, 0);
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
            done_next = 1'b0;
            if (rst) begin
                // outputs during the reset cycle itself are not yet defined
            end else if (rst_prev) begin
                chk("rst_ctl", {busy, done, en, valid, last}, 0);
                chk("rst_addr", addr, 0);
                chk("rst_data", data, 0);
                m_busy = 1'b0;
                acc_pend = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (acc_pend) begin m_busy = 1'b1; acc_pend = 1'b0; end
                if (done_due) m_busy = 1'b0;
                chk("done", done, done_due);
                chk("busy", busy, m_busy);
                if (done_due && m_total != 0) begin
                    chk("beat_count", m_beat, m_total);
                    if (scen == 1) chk("done_cyc", cyc - m_start, 8);
                end
                if (m_busy && m_rd < m_total) begin
                    if (en) begin
                        chk("rd_addr", addr, m_rd);
                        m_rd++;
                    end
                end else begin
                    chk("en_off", en, 0);
                end
                if (prev_stall) begin
                    chk("stall_valid", valid, 1);
                    chk("stall_data", data, prev_data);
                    chk("stall_last", last, prev_last);
                end
                if (!m_busy || m_beat >= m_total) begin
                    chk("valid_off", valid, 0);
                end else if (valid && out_ready) begin
                    chk("beat_data", data, mem[m_beat]);
                    chk("beat_last", last, (m_beat == m_total - 1));
                    if (scen == 1) begin
                        chk("beat_cyc", cyc - m_start, 2 + m_beat);
                        if (m_beat == 0) chk("beat0_lit", data, 32'h3F800000);
                    end
                    if (m_beat == m_total - 1) done_next = 1'b1;
                    m_beat++;
                end
                chk("outstanding", ((m_rd - m_beat) <= 2), 1);
                if (scen == 3 && m_busy && cyc == m_start + 20)
                    chk("stall_reads", m_rd, 2);
                prev_stall = valid && !out_ready;
                prev_data = data;
                prev_last = last;
                if (start && !m_busy && !acc_pend) begin
                    m_rd = 0;
                    m_beat = 0;
                    m_start = cyc;
                    if (M_val == 0 || N_val == 0) begin
                        m_total = 0;
                        done_next = 1'b1;
                    end else begin
                        m_total = int'(M_val) * int'(N_val);
                        acc_pend = 1'b1;
                    end
                end
            end
            done_due = done_next;
            rst_prev = rst;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            2: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic fill_mem(input bit lit);
        for (int i = 0; i < 256; i++)
            mem[i] = lit ? (32'h3F800000 + 32'(i)) : $urandom;
    endtask

    task automatic wait_done(input int budget, input bit repulse);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            step();
            k++;
            if (repulse && k == 4) begin start = 1'b1; M_val = 1; N_val = 1; end
            if (repulse && k == 5) start = 1'b0;
        end
        if (k >= budget) begin
            to_cnt++;
            $display("FAIL wait_done: no done within %0d cycles", budget);
        end
        step();
    endtask

    task automatic run_job(input int m, input int n, input int mode, input int sc, input bit repulse);
        fill_mem(sc == 1);
        scen = sc;
        rdy_mode = mode;
        step();
        start = 1'b1;
        M_val = (AM+1)'(m);
        N_val = (AN+1)'(n);
        step();
        start = 1'b0;
        wait_done(3000, repulse);
    endtask

    initial begin : driver
        rst = 1'b1;
        start = 1'b0;
        M_val = '0;
        N_val = '0;
        out_ready = 1'b0;
        fill_mem(1'b0);
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        run_job(2, 3, 0, 1, 1'b0);   // ascending words, ready held high
        run_job(4, 4, 1, 2, 1'b0);   // ready toggling every cycle
        run_job(3, 0, 0, 0, 1'b0);   // empty matrix
        run_job(0, 5, 2, 0, 1'b0);

        // 16x16 with the consumer stalled for 20 cycles after start
        fill_mem(1'b0);
        scen = 3;
        rdy_mode = 3;
        step();
        start = 1'b1; M_val = 16; N_val = 16;
        step();
        start = 1'b0;
        repeat (19) step();
        rdy_mode = 0;
        wait_done(3000, 1'b0);

        // reset right after beat 5 of a 4x4 drain
        fill_mem(1'b0);
        scen = 0;
        rdy_mode = 0;
        step();
        start = 1'b1; M_val = 4; N_val = 4;
        step();
        start = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        rdy_mode = 3;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        step();
        run_job(2, 2, 2, 0, 1'b0);

        run_job(4, 4, 2, 0, 1'b1);   // start re-pulsed while busy
        run_job(1, 1, 0, 0, 1'b0);
        run_job(16, 1, 1, 0, 1'b0);
        run_job(1, 16, 2, 0, 1'b0);
        for (int j = 0; j < 8; j++)
            run_job($urandom_range(1, 16), $urandom_range(1, 16), 2, 0, 1'b0);

        finish_req = 1'b1;
        repeat (3) step();
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/matrix_c_reader.md
MATRIX_C_READER -- requirements
Module: matrix_c_reader

Interface
REQ-001 Parameter MAX_M, default 16, max result rows.
REQ-002 Parameter MAX_N, default 16, max result columns.
REQ-003 Parameter ADDR_M_BITS, default $clog2(MAX_M), row index width.
REQ-004 Parameter ADDR_N_BITS, default $clog2(MAX_N), column index width.
REQ-005 Parameter ADDR_C_BITS, default $clog2(MAX_M*MAX_N), C BRAM address width.
REQ-006 The block SHALL use one clock; reset is synchronous and active-high.
REQ-007 Port list:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin drain of matrix C; sampled only in IDLE.
- M_val  input  ADDR_M_BITS+1  rows to drain.
- N_val  input  ADDR_N_BITS+1  columns to drain.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle completion pulse.
- matrix_C_en  output  1  BRAM read enable.
- matrix_C_addr  output  ADDR_C_BITS  BRAM read address, row-major r*N_val+c.
- matrix_C_rdata  input  32  BRAM read data, valid exactly 1 cycle after matrix_C_en.
- out_valid  output  1  stream beat valid.
- out_ready  input  1  downstream accept.
- out_data  output  32  result word (IEEE-754 single, passed unmodified).
- out_last  output  1  high on final beat of the matrix.

Function
REQ-008 States SHALL be IDLE, RUN, DRAIN; IDLE->RUN on start with M_val>0 and N_val>0; RUN->DRAIN after last read issued; DRAIN->IDLE after last beat handshake.
REQ-009 start with M_val==0 or N_val==0 SHALL produce done the next cycle, no reads, no beats, and remain in IDLE.
REQ-010 start while busy SHALL be ignored; M_val/N_val SHALL be latched on accepted start.
REQ-011 Reads SHALL be issued in address order 0..M_val*N_val-1 with no skips or repeats.
REQ-012 A beat transfers when out_valid && out_ready; out_data/out_last SHALL be held stable while out_valid && !out_ready.
REQ-013 Returned data SHALL enter a 2-entry FIFO; a read SHALL be issued only when (occupancy + reads in flight - pop this cycle) < 2, so data is never lost under backpressure.
REQ-014 With out_ready held high, throughput SHALL be 1 beat/cycle; first out_valid SHALL assert 2 cycles after the start cycle.
REQ-015 out_last SHALL be high only on beat M_val*N_val-1.
REQ-016 done SHALL pulse the cycle after the out_last handshake; busy SHALL fall in the same cycle.
REQ-017 Simultaneous push and pop on a full or empty FIFO SHALL keep occupancy correct (push+pop on full allowed; pop on empty impossible).
REQ-018 matrix_C_en SHALL be low in IDLE and DRAIN.

Reset
REQ-019 rst SHALL force IDLE, busy=0, done=0, matrix_C_en=0, matrix_C_addr=0, out_valid=0, out_last=0, out_data=0, FIFO empty, in-flight flag cleared.
REQ-020 rst mid-drain SHALL abort immediately; a BRAM return in the following cycle SHALL be discarded.

Structure
REQ-021 Shared package SHALL hold state encodings (IDLE/RUN/DRAIN) and the 32-bit word width constant.
REQ-022 The 2-entry FIFO SHALL be one sub-module, result_skid_fifo (width 32+1 incl. last).
REQ-023 Address generation SHALL use a row/column counter pair, not a multiplier per beat.

Verification
REQ-024 M=2,N=3, C preloaded 0x3F800000+i, ready=1 -> 6 beats in 6 consecutive cycles, data ascending, out_last on beat 5, done one cycle later.
REQ-025 M=4,N=4, ready toggled 1/0 per cycle -> 16 beats, no loss/duplication, data stable during stalls, at most 2 reads outstanding+buffered.
REQ-026 M=3,N=0 start -> done next cycle, matrix_C_en never asserted, no out_valid.
REQ-027 ready=0 for 20 cycles after start (M=N=16) -> exactly 2 reads issued, then 256 correct beats after ready=1.
REQ-028 rst asserted after beat 5 of a 4x4 drain -> next cycle all outputs at reset values; subsequent 2x2 start drains addresses 0..3 correctly.
REQ-029 start re-pulsed during busy -> ignored, beat count unchanged.
